nios_debug_scan_engine: RTL and testbench

Parametrised debug scan engine for the Nios II debug slave. It oversamples a JTAG-style virtual interface (tck, tdi, virtual-state strobes, IR) in the system clock domain. It captures and shifts a DR_WIDTH scan register, and on update issues per-instruction action strobes with a data word and a ready/valid handshake. It replaces the fixed 38-bit, 2-bit-IR debug slave pair and sits between the virtual JTAG primitive and the OCI break, memory and trace control logic.

---
 rtl/nios_dbg_pkg.sv | 12 +
 rtl/nios_dbg_sync.sv | 24 ++
 rtl/nios_debug_scan_engine.sv | 84 ++++++++
 tb/tb_nios_debug_scan_engine.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_dbg_pkg.sv
// nios_dbg_pkg: shared FSM type, width defaults and capture-word channel select
package nios_dbg_pkg;
  typedef enum logic {IDLE, PEND} state_t;
  localparam int DEF_DR_WIDTH = 38;
  localparam int DEF_IR_WIDTH = 2;
  localparam int MAX_DR = 256;
  localparam int MAX_CAP = 4096;
  function automatic logic [MAX_DR-1:0] ch_slice(input logic [MAX_CAP-1:0] cap, input logic [31:0] ch,
                                                 input logic [31:0] w);
    return MAX_DR'(cap >> (ch * w)) & ((MAX_DR'(1) << w) - MAX_DR'(1));
  endfunction
endpackage

// File: rtl/nios_dbg_sync.sv
// nios_dbg_sync: multi-bit synchroniser with rising-edge detect on the synchronised outputs
module nios_dbg_sync #(
  parameter int W = 1,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_rise
);
  logic [DEPTH-1:0][W-1:0] r_pipe;
  logic [W-1:0] r_prev;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_pipe <= '0;
      r_prev <= '0;
    end else begin
      r_pipe <= {r_pipe[DEPTH-2:0], i_d};
      r_prev <= r_pipe[DEPTH-1];
    end
  assign o_q = r_pipe[DEPTH-1];
  assign o_rise = o_q & ~r_prev;
endmodule

// File: rtl/nios_debug_scan_engine.sv
// nios_debug_scan_engine: clk-domain oversampled JTAG scan register with per-instruction action handshake
module nios_debug_scan_engine
  import nios_dbg_pkg::*;
#(
  parameter int DR_WIDTH = DEF_DR_WIDTH,
  parameter int IR_WIDTH = DEF_IR_WIDTH,
  parameter int SYNC_STAGES = 2,
  localparam int NUM_CH = 2 ** IR_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       tck,
  input  logic                       tdi,
  input  logic                       vs_cdr,
  input  logic                       vs_sdr,
  input  logic                       vs_udr,
  input  logic                       vs_uir,
  input  logic [IR_WIDTH-1:0]        ir_in,
  input  logic [NUM_CH*DR_WIDTH-1:0] capture_data,
  output logic                       tdo,
  output logic [DR_WIDTH-1:0]        jdo,
  output logic [NUM_CH-1:0]          take_action,
  output logic [NUM_CH-1:0]          take_no_action,
  input  logic                       action_ready,
  output logic                       overrun,
  input  logic                       clear_overrun
);
  localparam int SW = IR_WIDTH + 6;
  logic [SW-1:0] w_sync, w_rise;
  logic [DR_WIDTH-1:0] r_sr, r_jdo, w_cap;
  logic [IR_WIDTH-1:0] r_ir_q, r_act_ch;
  logic [NUM_CH-1:0] w_onehot;
  logic r_tdo, r_udr_rise, r_overrun, w_load, w_ovr_set, w_unused;
  state_t r_state, w_next;
  nios_dbg_sync #(.W(SW), .DEPTH(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .i_d    ({ir_in, vs_uir, vs_udr, vs_sdr, vs_cdr, tdi, tck}),
    .o_q    (w_sync),
    .o_rise (w_rise)
  );
  assign w_unused = ^{w_rise[SW-1:6], w_rise[3:1], w_sync[5:4], w_sync[0]};
  assign w_cap = DR_WIDTH'(ch_slice(MAX_CAP'(capture_data), 32'(r_ir_q), 32'(DR_WIDTH)));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_sr <= '0;
      r_tdo <= 1'b0;
      r_ir_q <= '0;
      r_udr_rise <= 1'b0;
    end else begin
      r_tdo <= r_sr[0];
      r_udr_rise <= w_rise[4];
      if (w_rise[5]) r_ir_q <= w_sync[6 +: IR_WIDTH];
      if (w_rise[0] && w_sync[2]) r_sr <= w_cap;
      else if (w_rise[0] && w_sync[3]) r_sr <= {w_sync[1], r_sr[DR_WIDTH-1:1]};
    end
  // the udr edge is registered once more so the strobe lands SYNC_STAGES+2 cycles after the pin
  always_comb begin
    w_next = r_state;
    w_load = (r_state == IDLE) && r_udr_rise;
    w_ovr_set = (r_state == PEND) && r_udr_rise;
    w_next = (r_state == IDLE) ? (r_udr_rise ? PEND : IDLE) : (action_ready ? IDLE : PEND);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_jdo <= '0;
      r_act_ch <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_next;
      r_overrun <= w_ovr_set | (r_overrun & ~clear_overrun);
      if (w_load) begin
        r_jdo <= r_sr;
        r_act_ch <= r_ir_q;
      end
    end
  assign w_onehot = NUM_CH'(1) << r_act_ch;
  assign take_action = (r_state == PEND && r_jdo[DR_WIDTH-1]) ? w_onehot : '0;
  assign take_no_action = (r_state == PEND && !r_jdo[DR_WIDTH-1]) ? w_onehot : '0;
  assign tdo = r_tdo;
  assign jdo = r_jdo;
  assign overrun = r_overrun;
endmodule

// File: tb/tb_nios_debug_scan_engine.sv
// tb_nios_debug_scan_engine: directed + randomised checks of default (38/2) and wide (64/3) engines against a bench model
module tb_nios_debug_scan_engine;
  logic clk = 1'b0;
  logic reset_n, tck, tdi, vs_cdr, vs_sdr, vs_udr, vs_uir, action_ready, clear_overrun;
  logic [2:0] ir;
  logic [151:0] cap_a;
  logic [511:0] cap_b;
  logic tdo_a, tdo_b, ovr_a, ovr_b;
  logic [37:0] jdo_a;
  logic [63:0] jdo_b;
  logic [3:0] ta_a, tna_a;
  logic [7:0] ta_b, tna_b;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  nios_debug_scan_engine u_a (
    .clk(clk), .reset_n(reset_n), .tck(tck), .tdi(tdi), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr),
    .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir[1:0]), .capture_data(cap_a), .tdo(tdo_a),
    .jdo(jdo_a), .take_action(ta_a), .take_no_action(tna_a), .action_ready(action_ready),
    .overrun(ovr_a), .clear_overrun(clear_overrun)
  );
  nios_debug_scan_engine #(.DR_WIDTH(64), .IR_WIDTH(3)) u_b (
    .clk(clk), .reset_n(reset_n), .tck(tck), .tdi(tdi), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr),
    .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir), .capture_data(cap_b), .tdo(tdo_b),
    .jdo(jdo_b), .take_action(ta_b), .take_no_action(tna_b), .action_ready(action_ready),
    .overrun(ovr_b), .clear_overrun(clear_overrun)
  );

  logic        o_tdo [2];
  logic        o_ovr [2];
  logic [63:0] o_jdo [2];
  logic [7:0]  o_ta  [2];
  logic [7:0]  o_tna [2];
  assign o_tdo[0] = tdo_a;
  assign o_tdo[1] = tdo_b;
  assign o_ovr[0] = ovr_a;
  assign o_ovr[1] = ovr_b;
  assign o_jdo[0] = 64'(jdo_a);
  assign o_jdo[1] = jdo_b;
  assign o_ta[0] = 8'(ta_a);
  assign o_ta[1] = ta_b;
  assign o_tna[0] = 8'(tna_a);
  assign o_tna[1] = tna_b;

  // behavioural model: what each engine's scan register and action slot should hold
  int          dw [2] = '{38, 64};
  logic [63:0] cap_word [2][8];
  logic [63:0] m_sr [2];
  logic [63:0] m_jdo [2];
  logic [2:0]  m_ir [2];
  logic [2:0]  m_ch [2];
  bit          m_pend [2];
  bit          m_ovr [2];
  logic [63:0] k_beef = 64'h2A_DEAD_BEEF;

  function automatic logic [63:0] mask(int d);
    return (dw[d] == 64) ? '1 : ((64'd1 << dw[d]) - 64'd1);
  endfunction

  function automatic logic [7:0] exp_strobe(int d, logic want);
    return (m_pend[d] && m_jdo[d][dw[d]-1] == want) ? (8'd1 << m_ch[d]) : 8'd0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_sr[d] = '0; m_jdo[d] = '0; m_ir[d] = '0; m_ch[d] = '0; m_pend[d] = 0; m_ovr[d] = 0;
    end
  endtask

  task automatic model_udr();
    for (int d = 0; d < 2; d++)
      if (m_pend[d]) m_ovr[d] = 1;
      else begin
        m_pend[d] = 1; m_jdo[d] = m_sr[d]; m_ch[d] = m_ir[d];
      end
  endtask

  task automatic model_accept();
    for (int d = 0; d < 2; d++) m_pend[d] = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s.tdo%0d", tag, d), 64'(o_tdo[d]), 64'(m_sr[d][0]));
      chk($sformatf("%s.jdo%0d", tag, d), o_jdo[d], m_jdo[d]);
      chk($sformatf("%s.ta%0d", tag, d), 64'(o_ta[d]), 64'(exp_strobe(d, 1'b1)));
      chk($sformatf("%s.tna%0d", tag, d), 64'(o_tna[d]), 64'(exp_strobe(d, 1'b0)));
      chk($sformatf("%s.ovr%0d", tag, d), 64'(o_ovr[d]), 64'(m_ovr[d]));
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_caps();
    for (int k = 0; k < 4; k++) cap_a[k*38 +: 38] = cap_word[0][k][37:0];
    for (int k = 0; k < 8; k++) cap_b[k*64 +: 64] = cap_word[1][k];
  endtask

  task automatic rand_caps();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 8; k++) cap_word[d][k] = {$urandom(), $urandom()} & mask(d);
    set_caps();
  endtask

  task automatic tck_bit(input logic b);
    tdi = b; tck = 1'b1; step(4);
    tck = 1'b0; step(4);
    for (int d = 0; d < 2; d++)
      if (vs_cdr) m_sr[d] = cap_word[d][m_ir[d]];
      else if (vs_sdr) m_sr[d] = (m_sr[d] >> 1) | (64'(b) << (dw[d] - 1));
  endtask

  task automatic jtag_ir(input logic [2:0] v);
    ir = v; vs_uir = 1'b1; step(4);
    vs_uir = 1'b0; step(4);
    m_ir[0] = {1'b0, v[1:0]};
    m_ir[1] = v;
  endtask

  task automatic capture();
    vs_cdr = 1'b1; tck_bit(1'b0); vs_cdr = 1'b0;
  endtask

  task automatic shift_in(input logic [63:0] w, input int n);
    vs_sdr = 1'b1;
    for (int i = 0; i < n; i++) tck_bit(w[i]);
    vs_sdr = 1'b0;
  endtask

  task automatic udr();
    vs_udr = 1'b1; step(4);
    model_udr();
    if (action_ready) model_accept();
    vs_udr = 1'b0; step(4);
  endtask

  task automatic accept();
    action_ready = 1'b1; step(1);
    model_accept();
  endtask

  initial begin
    logic [63:0] w;
    {tck, tdi, vs_cdr, vs_sdr, vs_udr, vs_uir, action_ready, clear_overrun} = '0;
    ir = '0; reset_n = 1'b0;
    model_reset();
    rand_caps();
    cap_word[0][2] = k_beef;
    set_caps();
    step(3);
    check_all("reset");
    reset_n = 1'b1; step(2);
    // capture channel 2 and stream it out with tdi=0
    jtag_ir(3'd2); capture();
    check_all("cap");
    vs_sdr = 1'b1;
    for (int i = 0; i < 38; i++) begin
      chk("tdo_stream", 64'(tdo_a), (k_beef >> i) & 64'd1);
      chk("tdo_stream_b", 64'(tdo_b), 64'(m_sr[1][0]));
      tck_bit(1'b0);
    end
    vs_sdr = 1'b0;
    // MSB=1 word with action_ready high: strobe at exactly SYNC_STAGES+2 and lasting one cycle
    action_ready = 1'b1;
    shift_in(64'h20_0000_0001, 38);
    vs_udr = 1'b1; step(3);
    chk("lat_pre_a", 64'(ta_a), 64'd0);
    chk("lat_pre_b", 64'(ta_b), 64'd0);
    step(1); model_udr();
    chk("ta_const", 64'(ta_a), 64'h4);
    chk("jdo_const", 64'(jdo_a), 64'h20_0000_0001);
    check_all("strobe");
    step(1); model_accept();
    check_all("strobe_gone");
    vs_udr = 1'b0; step(4);
    check_all("after_ack");
    // MSB=0 word held, second update overruns
    action_ready = 1'b0;
    shift_in(64'h0_1234_5678, 38); udr();
    chk("tna_const", 64'(tna_a), 64'h4);
    check_all("held");
    shift_in({$urandom(), $urandom()}, 38); udr();
    chk("ovr_jdo", 64'(jdo_a), 64'h0_1234_5678);
    check_all("overrun");
    accept();
    check_all("accept_ovr");
    clear_overrun = 1'b1; step(1); clear_overrun = 1'b0;
    for (int d = 0; d < 2; d++) m_ovr[d] = 0;
    check_all("clear_ovr");
    // overrun event coinciding with clear_overrun keeps the flag
    action_ready = 1'b0; step(1);
    shift_in({$urandom(), $urandom()}, 64); udr();
    check_all("pend2");
    clear_overrun = 1'b1; vs_udr = 1'b1; step(4);
    chk("ovr_set_wins_a", 64'(ovr_a), 64'd1);
    chk("ovr_set_wins_b", 64'(ovr_b), 64'd1);
    step(1);
    chk("ovr_cleared_a", 64'(ovr_a), 64'd0);
    chk("ovr_cleared_b", 64'(ovr_b), 64'd0);
    clear_overrun = 1'b0; vs_udr = 1'b0; step(4);
    check_all("pend2_hold");
    accept();
    check_all("pend2_ack");
    // capture and shift together: capture wins
    jtag_ir(3'd1);
    vs_cdr = 1'b1; vs_sdr = 1'b1; tck_bit(1'b1); vs_cdr = 1'b0; vs_sdr = 1'b0;
    udr();
    chk("cdr_wins", 64'(jdo_a), cap_word[0][1]);
    check_all("cdr_wins");
    // reset mid-shift
    vs_sdr = 1'b1;
    tck_bit(1'b1); tck_bit(1'b1); tck_bit(1'b0);
    tck = 1'b1; step(2);
    reset_n = 1'b0; #1;
    model_reset();
    check_all("rst_shift");
    tck = 1'b0; vs_sdr = 1'b0; step(2);
    reset_n = 1'b1; step(2);
    // reset while a strobe is pending
    action_ready = 1'b0;
    jtag_ir(3'd3); capture();
    w = {$urandom(), $urandom()};
    w[37] = 1'b1; w[63] = 1'b1;
    shift_in(w, 64); udr();
    check_all("pend3");
    reset_n = 1'b0; #1;
    model_reset();
    check_all("rst_pend");
    step(2); reset_n = 1'b1; step(10);
    check_all("post_rst");
    // channel sweep: strobe index follows ir on the 64/3 engine
    for (int c = 0; c < 8; c++) begin
      rand_caps();
      jtag_ir(3'(c)); capture();
      check_all("sweep_cap");
      w = {$urandom(), $urandom()};
      shift_in(w, 64);
      action_ready = 1'b0; udr();
      chk("sweep_jdo", jdo_b, w);
      chk("sweep_idx", 64'(ta_b | tna_b), 64'd1 << c);
      check_all("sweep_pend");
      accept(); step(1);
      check_all("sweep_ack");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
